// File: rtl/mgmt_rx_frame_reader.sv
`default_nettype none
// mgmt_rx_frame_reader: pops RX frame headers, streams ceil(len/4) words, drains corrupt/discarded frames.
// Rev 1.0 -- define MGMT_RX_STATS_EN to build the saturating stat_frames/stat_drops counters.
module mgmt_rx_frame_reader #(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_WIDTH     = 11
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rxheader_rd_empty,
  output logic                 rxheader_rd_en,
  input  logic [LEN_WIDTH-1:0] rxheader_rd_data,
  output logic                 rxfifo_rd_en,
  output logic                 rxfifo_rd_pop_single,
  input  logic [31:0]          rxfifo_rd_data,
  output logic                 frame_ready,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data,
  output logic                 m_last,
  output logic [2:0]           m_bytes,
  input  logic                 discard,
  output logic [31:0]          stat_frames,
  output logic [15:0]          stat_drops
);
  localparam int WL_W = LEN_WIDTH - 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HDR    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);

  logic [1:0]           state_q, state_d;
  logic [WL_W-1:0]      words_left_q;
  logic [LEN_WIDTH-1:0] frame_len_q;
  logic                 frame_ready_q;
  logic [1:0][31:0]     buf_data_q;
  logic [1:0]           buf_last_q;
  logic [1:0]           buf_cnt_q;
  logic                 rd_ptr_q, wr_ptr_q;
  logic                 pend_q, pend_last_q;

  logic [LEN_WIDTH:0]   w_len_p3;
  logic [WL_W-1:0]      w_hdr_words;
  logic                 w_hdr_bad;
  logic                 w_valid, w_pop, w_last_acc, w_wl_nz, w_rd_stream;
  logic [1:0]           w_occ;
  logic [2:0]           w_tail;

  assign w_len_p3    = {1'b0, rxheader_rd_data} + (LEN_WIDTH+1)'(3);
  assign w_hdr_words = w_len_p3[LEN_WIDTH:2];
  assign w_hdr_bad   = (rxheader_rd_data == '0) || (rxheader_rd_data > MAX_LEN);
  assign w_valid     = (state_q == S_STREAM) && (buf_cnt_q != 2'd0);
  assign w_pop       = w_valid && m_ready;
  assign w_last_acc  = w_pop && buf_last_q[rd_ptr_q];
  assign w_wl_nz     = (words_left_q != '0);
  // Occupancy after this cycle's pop; a new read is allowed only if its word will still fit.
  assign w_occ       = buf_cnt_q + {1'b0, pend_q} - {1'b0, w_pop};
  assign w_rd_stream = (state_q == S_STREAM) && w_wl_nz && (w_occ < 2'd2);
  assign w_tail      = (frame_len_q[1:0] == 2'd0) ? 3'd4 : {1'b0, frame_len_q[1:0]};

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rxheader_rd_empty) state_d = S_HDR;
      S_HDR:    state_d = w_hdr_bad ? S_DRAIN : S_STREAM;
      S_STREAM: begin
        if (w_last_acc)   state_d = S_IDLE;
        else if (discard) state_d = S_DRAIN;
      end
      S_DRAIN:  if (!w_wl_nz) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rxheader_rd_en = 1'b0;
    rxfifo_rd_en   = 1'b0;
    m_valid        = 1'b0;
    case (state_q)
      S_IDLE:   rxheader_rd_en = !rxheader_rd_empty && !rst;
      S_STREAM: begin
        rxfifo_rd_en = w_rd_stream;
        m_valid      = w_valid;
      end
      S_DRAIN:  rxfifo_rd_en = w_wl_nz;
      default:  ;
    endcase
  end

  assign rxfifo_rd_pop_single = rxfifo_rd_en;
  assign frame_ready          = frame_ready_q;
  assign frame_len            = frame_len_q;
  assign m_data               = buf_data_q[rd_ptr_q];
  assign m_last               = w_valid && buf_last_q[rd_ptr_q];
  assign m_bytes              = !w_valid ? 3'd0 : (buf_last_q[rd_ptr_q] ? w_tail : 3'd4);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      words_left_q  <= '0;
      frame_len_q   <= '0;
      frame_ready_q <= 1'b0;
      buf_data_q    <= '0;
      buf_last_q    <= '0;
      buf_cnt_q     <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
    end else begin
      if (state_q == S_HDR) begin
        frame_len_q  <= rxheader_rd_data;
        words_left_q <= w_hdr_words;
      end else if (rxfifo_rd_en) begin
        words_left_q <= words_left_q - WL_W'(1);
      end
      pend_q      <= w_rd_stream;
      pend_last_q <= (words_left_q == WL_W'(1));
      // Outside STREAM any returning or buffered word belongs to a dropped frame.
      if (state_q == S_STREAM) begin
        if (pend_q) begin
          buf_data_q[wr_ptr_q] <= rxfifo_rd_data;
          buf_last_q[wr_ptr_q] <= pend_last_q;
          wr_ptr_q             <= ~wr_ptr_q;
        end
        if (w_pop) rd_ptr_q <= ~rd_ptr_q;
        buf_cnt_q <= w_occ;
      end else begin
        buf_cnt_q <= 2'd0;
        rd_ptr_q  <= 1'b0;
        wr_ptr_q  <= 1'b0;
      end
      if ((state_q == S_HDR) && !w_hdr_bad)
        frame_ready_q <= 1'b1;
      else if (((state_q == S_STREAM) && w_last_acc) || ((state_q == S_DRAIN) && !w_wl_nz))
        frame_ready_q <= 1'b0;
    end
  end

`ifdef MGMT_RX_STATS_EN
  logic [31:0] frames_q;
  logic [15:0] drops_q;
  logic        w_frame_inc, w_drop_inc;

  assign w_frame_inc = (state_q == S_STREAM) && w_last_acc;
  assign w_drop_inc  = ((state_q == S_HDR) && w_hdr_bad) ||
                       ((state_q == S_STREAM) && discard && !w_last_acc);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      if (w_frame_inc && (frames_q != '1)) frames_q <= frames_q + 32'd1;
      if (w_drop_inc && (drops_q != '1))   drops_q  <= drops_q + 16'd1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_drops  = drops_q;
`else
  assign stat_frames = '0;
  assign stat_drops  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mgmt_rx_frame_reader.sv
`default_nettype none
// tb_mgmt_rx_frame_reader: random frames through queue-modelled header/data FIFOs and a word-list scoreboard.
module tb_mgmt_rx_frame_reader;
  logic        sys_clk = 1'b0;
  logic        rst;
  logic        rxheader_rd_empty;
  logic        rxheader_rd_en;
  logic [10:0] rxheader_rd_data;
  logic        rxfifo_rd_en;
  logic        rxfifo_rd_pop_single;
  logic [31:0] rxfifo_rd_data;
  logic        frame_ready;
  logic [10:0] frame_len;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [2:0]  m_bytes;
  logic        discard;
  logic [31:0] stat_frames;
  logic [15:0] stat_drops;

  int n_cmp = 0;
  int n_err = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  logic [31:0] data_q[$];

  mgmt_rx_frame_reader dut (
    .sys_clk(sys_clk), .rst(rst),
    .rxheader_rd_empty(rxheader_rd_empty), .rxheader_rd_en(rxheader_rd_en),
    .rxheader_rd_data(rxheader_rd_data),
    .rxfifo_rd_en(rxfifo_rd_en), .rxfifo_rd_pop_single(rxfifo_rd_pop_single),
    .rxfifo_rd_data(rxfifo_rd_data),
    .frame_ready(frame_ready), .frame_len(frame_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_bytes(m_bytes),
    .discard(discard), .stat_frames(stat_frames), .stat_drops(stat_drops)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_stats();
`ifdef MGMT_RX_STATS_EN
    check("stat_frames", stat_frames, exp_frames);
    check("stat_drops", 32'(stat_drops), exp_drops);
`else
    check("stat_frames", stat_frames, 0);
    check("stat_drops", 32'(stat_drops), 0);
`endif
  endtask

  // Called at posedge+1. disc_after: pulse discard the cycle after that many words were accepted.
  // rst_after: assert reset the cycle after that many words were accepted, then abandon the frame.
  task automatic run_frame(input int len, input int rmode, input int disc_after, input int rst_after);
    int total, lb, acc, reads, ps, cyc, first_v, last_v, vcnt;
    bit bad, done, dropped, disc_pend, hdr_en_s, rd_en_s, pop, do_rst, hdr_taken;
    logic [31:0] exp_w[$];
    logic [31:0] w;
    total = (len + 3) / 4;
    lb    = (len % 4 == 0) ? 4 : len % 4;
    bad   = (len == 0) || (len > 1518);
    acc = 0; reads = 0; ps = 0; cyc = 0; first_v = -1; last_v = -1; vcnt = 0;
    done = 0; dropped = 0; disc_pend = 0; do_rst = 0; hdr_taken = 0;
    for (int i = 0; i < total; i++) begin
      w = $urandom;
      data_q.push_back(w);
      exp_w.push_back(w);
    end
    if (bad) exp_drops++;
    rxheader_rd_empty = 1'b0;
    while (!done && cyc < 6 * total + 40) begin
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      discard   = disc_pend;
      disc_pend = 0;
      #4;
      pop = m_valid && m_ready;
      if (m_valid) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (bad || dropped || acc >= total) begin
          check("valid_without_frame", 32'(m_valid), 0);
        end else begin
          check("data", m_data, exp_w[acc]);
          check("last", 32'(m_last), 32'(acc == total - 1));
          check("bytes", 32'(m_bytes), (acc == total - 1) ? lb : 4);
          check("frame_len", 32'(frame_len), len);
          check("frame_ready", 32'(frame_ready), 1);
        end
      end
      if (rxfifo_rd_en && !bad && !dropped)
        check("outstanding_le2", 32'((reads + 1 - (acc + int'(pop))) <= 2), 1);
      if (rxheader_rd_en && rxheader_rd_empty)
        check("hdr_pop_when_empty", 32'(rxheader_rd_en), 0);
      if (pop && !bad && !dropped) begin
        acc++;
        if (m_last) begin
          done = 1;
          exp_frames++;
        end
        if (acc == disc_after) disc_pend = 1;
        if (acc == rst_after) do_rst = 1;
      end
      if (discard && !done && !dropped) begin
        dropped = 1;
        exp_drops++;
      end
      hdr_en_s = rxheader_rd_en;
      rd_en_s  = rxfifo_rd_en;
      if (rd_en_s) reads++;
      if (rxfifo_rd_pop_single) ps++;
      if ((bad || dropped) && hdr_taken && reads == total && !rd_en_s && !frame_ready) done = 1;
      @(posedge sys_clk); #1;
      cyc++;
      if (hdr_en_s && !hdr_taken) begin
        rxheader_rd_data  = 11'(len);
        rxheader_rd_empty = 1'b1;
        hdr_taken = 1;
      end
      if (rd_en_s) begin
        if (data_q.size() > 0) rxfifo_rd_data = data_q.pop_front();
        else check("data_overread", 1, 0);
      end
      if (do_rst) begin
        #2 rst = 1'b1;
        #1;
        check("rst_ctl", 32'({m_valid, m_last, frame_ready, rxheader_rd_en, rxfifo_rd_en, rxfifo_rd_pop_single}), 0);
        check("rst_data", m_data, 0);
        check("rst_len_bytes", 32'({m_bytes, frame_len}), 0);
        check("rst_stats", stat_frames | 32'(stat_drops), 0);
        exp_frames = 0;
        exp_drops  = 0;
        data_q.delete();
        rxheader_rd_empty = 1'b1;
        m_ready = 1'b0;
        discard = 1'b0;
        @(negedge sys_clk) rst = 1'b0;
        @(posedge sys_clk); #1;
        return;
      end
    end
    if (!done) check("frame_timeout", 0, 1);
    discard = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("quiet_valid", 32'(m_valid), 0);
      check("quiet_rd", 32'(rxfifo_rd_en), 0);
      if (rxfifo_rd_en) reads++;
      @(posedge sys_clk); #1;
    end
    check("reads_total", reads, total);
    check("pop_single_total", ps, total);
    check("frame_ready_end", 32'(frame_ready), 0);
    if (rmode == 0 && !bad && disc_after < 0) begin
      check("valid_count", vcnt, total);
      check("valid_contiguous", last_v - first_v + 1, total);
    end
    check_stats();
  endtask

  initial begin
    int len, rm, da;
    rst = 1'b1;
    rxheader_rd_empty = 1'b0;
    rxheader_rd_data  = '0;
    rxfifo_rd_data    = '0;
    m_ready = 1'b0;
    discard = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_ctl", 32'({m_valid, m_last, frame_ready, rxheader_rd_en, rxfifo_rd_en, rxfifo_rd_pop_single}), 0);
    check("reset_data", m_data, 0);
    check("reset_len_bytes", 32'({m_bytes, frame_len}), 0);
    check("reset_stats", stat_frames | 32'(stat_drops), 0);
    rxheader_rd_empty = 1'b1;
    @(negedge sys_clk) rst = 1'b0;
    @(posedge sys_clk); #1;

    run_frame(64, 0, -1, -1);
    run_frame(61, 0, -1, -1);
    run_frame(100, 1, -1, -1);
    run_frame(1500, 0, 10, -1);
    run_frame(40, 0, 9, -1);
    run_frame(400, 2, -1, 60);
    run_frame(8, 0, -1, -1);
    run_frame(0, 0, -1, -1);
    run_frame(2000, 0, -1, -1);
    run_frame(4, 0, -1, -1);
    run_frame(1518, 0, -1, -1);
    run_frame(1519, 2, -1, -1);

    for (int f = 0; f < 15; f++) begin
      len = $urandom_range(1, 1518);
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1519, 2047);
      rm = $urandom_range(0, 2);
      da = -1;
      if (len > 8 && len <= 1518 && $urandom_range(0, 2) == 0) da = $urandom_range(1, (len + 3) / 4 - 1);
      run_frame(len, rm, da, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
